// File: rtl/adc_fifo_writer_if.sv
// Serial ADC and FIFO write-side signals of adc_fifo_writer.
// master = the writer block, slave = the ADC/FIFO side.
interface adc_fifo_writer_if;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_sdata;
    logic [11:0] fifo_data;
    logic        fifo_wrreq;
    logic        fifo_full;

    modport master (
        output adc_cs_n, adc_sclk, fifo_data, fifo_wrreq,
        input  adc_sdata, fifo_full
    );

    modport slave (
        input  adc_cs_n, adc_sclk, fifo_data, fifo_wrreq,
        output adc_sdata, fifo_full
    );
endinterface

// File: rtl/adc_fifo_writer.sv
// Frames a 16-clock serial ADC conversion every SAMPLE_PERIOD cycles and
// writes the 12-bit offset-binary result into a FIFO, CAPTURE_LEN times.
module adc_fifo_writer #(
    parameter int unsigned SAMPLE_PERIOD = 50,
    parameter int unsigned CAPTURE_LEN   = 8192,
    parameter bit          TWOS_COMP_IN  = 1'b0
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    input  logic                sys_start_pulse,
    adc_fifo_writer_if.master   bus,
    output logic                capture_busy,
    output logic                capture_done,
    output logic                overflow,
    output logic [15:0]         sample_cnt
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;

    localparam logic [15:0] T_LAST  = 16'(SAMPLE_PERIOD - 1);
    localparam logic [15:0] CNT_END = 16'(CAPTURE_LEN);

    state_e      state_q, state_d;
    logic [15:0] t_q, t_d;
    logic [11:0] sr_q, sr_d;
    logic [11:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;

    logic        in_cap, frame_end, wr_slot, wr, sample_edge;
    logic [11:0] word;

    always_comb begin
        in_cap    = (state_q == CAPTURE);
        frame_end = in_cap && (t_q == T_LAST);
        wr_slot   = in_cap && (t_q == 16'd33) && !sys_start_pulse;
        wr        = wr_slot && !bus.fifo_full;
        // Only frame bits 2..13 (sampled at t=6..28) carry data, so the
        // ignored leading/trailing bits are never shifted in.
        sample_edge = in_cap && (t_q >= 16'd6) && (t_q <= 16'd28) && !t_q[0];
        word = sr_q;
        if (TWOS_COMP_IN) word[11] = ~sr_q[11];

        state_d = state_q;
        t_d     = t_q;
        sr_d    = sr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (sample_edge) sr_d = {sr_q[10:0], bus.adc_sdata};
        if (wr) data_d = word;
        if (wr_slot) begin
            cnt_d = cnt_q + 16'd1;
            if (bus.fifo_full) ovf_d = 1'b1;
        end

        case (state_q)
            CAPTURE: begin
                if (frame_end) begin
                    t_d = '0;
                    if (cnt_q == CNT_END) state_d = DONE;
                end else begin
                    t_d = t_q + 16'd1;
                end
            end
            default: ;
        endcase

        // Aborting while chip select is low parks t on the last (cs high)
        // slot so the ADC sees one deselected cycle before the new frame.
        if (sys_start_pulse) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            t_d     = (in_cap && (t_q <= 16'd32)) ? T_LAST : '0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        bus.adc_cs_n   = !(in_cap && (t_q <= 16'd32));
        bus.adc_sclk   = !(in_cap && t_q[0] && (t_q <= 16'd31));
        bus.fifo_wrreq = wr;
        bus.fifo_data  = wr ? word : data_q;
        capture_busy   = in_cap;
        capture_done   = (state_q == DONE);
        overflow       = ovf_q;
        sample_cnt     = cnt_q;
    end

endmodule

// File: tb/tb_adc_fifo_writer.sv
// Scoreboard bench: two writer instances (offset-binary and two's-complement
// input) fed by serial ADC models; expected FIFO words queued per test.
`timescale 1ns/1ps
module tb_adc_fifo_writer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] cnt_a, cnt_b;

    adc_fifo_writer_if ifa();
    adc_fifo_writer_if ifb();

    adc_fifo_writer #(.SAMPLE_PERIOD(50), .CAPTURE_LEN(4), .TWOS_COMP_IN(1'b0)) dut_a (
        .clk_50M(clk), .rst_n(rst_n), .sys_start_pulse(start_a), .bus(ifa),
        .capture_busy(busy_a), .capture_done(done_a), .overflow(ovf_a), .sample_cnt(cnt_a));

    adc_fifo_writer #(.SAMPLE_PERIOD(50), .CAPTURE_LEN(3), .TWOS_COMP_IN(1'b1)) dut_b (
        .clk_50M(clk), .rst_n(rst_n), .sys_start_pulse(start_b), .bus(ifb),
        .capture_busy(busy_b), .capture_done(done_b), .overflow(ovf_b), .sample_cnt(cnt_b));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [11:0] adc_a[$], adc_b[$];
    logic [11:0] exp_a[$], exp_b[$];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: word chosen at cs_n fall, bit i driven after i-th sclk fall.
    logic [15:0] fw_a, fw_b;
    int idx_a, idx_b;
    always @(negedge ifa.adc_cs_n) begin
        fw_a  = {2'b00, (adc_a.size() > 0) ? adc_a.pop_front() : 12'h000, 2'b00};
        idx_a = 0;
    end
    always @(negedge ifa.adc_sclk) begin
        #2;
        if (idx_a < 16) ifa.adc_sdata = fw_a[15 - idx_a];
        idx_a++;
    end
    always @(negedge ifb.adc_cs_n) begin
        fw_b  = {2'b00, (adc_b.size() > 0) ? adc_b.pop_front() : 12'h000, 2'b00};
        idx_b = 0;
    end
    always @(negedge ifb.adc_sclk) begin
        #2;
        if (idx_b < 16) ifb.adc_sdata = fw_b[15 - idx_b];
        idx_b++;
    end

    int wr_cnt_a = 0, wr_cnt_b = 0;
    int low_a = 0, fall_a = 0, low_b = 0, last_wr_b = 0;
    logic prev_cs_a = 1'b1, prev_sclk_a = 1'b1, prev_cs_b = 1'b1;

    always @(negedge clk) begin
        if (!ifa.adc_cs_n) begin
            if (prev_cs_a) begin low_a = 0; fall_a = 0; end
            low_a++;
        end else begin
            check_eq("a_sclk_idle_when_cs_high", ifa.adc_sclk, 1);
        end
        if (prev_sclk_a && !ifa.adc_sclk) fall_a++;
        if (ifa.fifo_wrreq) begin
            check_eq("a_wr_first_cycle_after_cs", prev_cs_a, 0);
            check_eq("a_cs_low_len", low_a, 33);
            check_eq("a_sclk_falls", fall_a, 16);
            check_eq("a_wr_expected", exp_a.size() > 0, 1);
            if (exp_a.size() > 0) check_eq("a_fifo_data", ifa.fifo_data, exp_a.pop_front());
            wr_cnt_a++;
        end
        prev_cs_a   = ifa.adc_cs_n;
        prev_sclk_a = ifa.adc_sclk;

        if (!ifb.adc_cs_n) begin
            if (prev_cs_b) low_b = 0;
            low_b++;
        end
        if (ifb.fifo_wrreq) begin
            check_eq("b_cs_low_len", low_b, 33);
            if (wr_cnt_b > 0) check_eq("b_wr_period", cyc - last_wr_b, 50);
            check_eq("b_wr_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) check_eq("b_fifo_data", ifb.fifo_data, exp_b.pop_front());
            last_wr_b = cyc;
            wr_cnt_b++;
        end
        prev_cs_b = ifb.adc_cs_n;
    end

    task automatic pulse_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (done_a) break;
        end
        check_eq(tag, done_a, 1);
    endtask

    task automatic wait_wr_a(input string tag, input int target);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (wr_cnt_a >= target) break;
        end
        check_eq(tag, wr_cnt_a, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cs_n"}, ifa.adc_cs_n, 1);
        check_eq({tag, "_sclk"}, ifa.adc_sclk, 1);
        check_eq({tag, "_wrreq"}, ifa.fifo_wrreq, 0);
        check_eq({tag, "_data"}, ifa.fifo_data, 0);
        check_eq({tag, "_busy"}, busy_a, 0);
        check_eq({tag, "_done"}, done_a, 0);
        check_eq({tag, "_ovf"}, ovf_a, 0);
        check_eq({tag, "_cnt"}, cnt_a, 0);
        check_eq({tag, "_b_cs_n"}, ifb.adc_cs_n, 1);
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ifa.fifo_full = 1'b0; ifb.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_cs_n", ifa.adc_cs_n, 1);

        // Plain capture on A, two's-complement conversion on B.
        foreach (adc_a[i]) ;
        adc_a.push_back(12'h000); adc_a.push_back(12'hFFF); adc_a.push_back(12'hA5A); adc_a.push_back(12'h5A5);
        exp_a.push_back(12'h000); exp_a.push_back(12'hFFF); exp_a.push_back(12'hA5A); exp_a.push_back(12'h5A5);
        adc_b.push_back(12'h800); adc_b.push_back(12'h123); adc_b.push_back(12'h7FF);
        exp_b.push_back(12'h000); exp_b.push_back(12'h923); exp_b.push_back(12'hFFF);
        @(negedge clk) begin start_a = 1'b1; start_b = 1'b1; end
        @(negedge clk) begin start_a = 1'b0; start_b = 1'b0; end
        check_eq("busy_after_start", busy_a, 1);
        wait_done_a("t1_done_a_timeout");
        for (int i = 0; i < 200 && !done_b; i++) @(negedge clk);
        check_eq("t1_done_b", done_b, 1);
        check_eq("t1_cnt_a", cnt_a, 4);
        check_eq("t1_cnt_b", cnt_b, 3);
        check_eq("t1_busy_a", busy_a, 0);
        check_eq("t1_ovf_a", ovf_a, 0);
        repeat (120) @(negedge clk);
        check_eq("t1_cs_stays_high", ifa.adc_cs_n, 1);
        check_eq("t1_wr_cnt_a", wr_cnt_a, 4);
        check_eq("t1_wr_cnt_b", wr_cnt_b, 3);
        check_eq("t1_cnt_a_held", cnt_a, 4);
        check_eq("t1_data_held", ifa.fifo_data, 12'h5A5);
        check_eq("t1_exp_a_empty", exp_a.size(), 0);
        check_eq("t1_exp_b_empty", exp_b.size(), 0);

        // FIFO full during frame 2 only.
        wr_cnt_a = 0;
        adc_a.push_back(12'h111); adc_a.push_back(12'h222); adc_a.push_back(12'h333); adc_a.push_back(12'h444);
        exp_a.push_back(12'h111); exp_a.push_back(12'h333); exp_a.push_back(12'h444);
        pulse_a();
        check_eq("t2_done_cleared", done_a, 0);
        wait_wr_a("t2_first_wr", 1);
        @(negedge clk) ifa.fifo_full = 1'b1;
        repeat (50) @(negedge clk);
        ifa.fifo_full = 1'b0;
        check_eq("t2_ovf_set", ovf_a, 1);
        check_eq("t2_wr_cnt_mid", wr_cnt_a, 1);
        wait_done_a("t2_done_timeout");
        check_eq("t2_ovf_sticky", ovf_a, 1);
        check_eq("t2_cnt", cnt_a, 4);
        check_eq("t2_wr_cnt", wr_cnt_a, 3);
        check_eq("t2_exp_empty", exp_a.size(), 0);

        // Overflow in frame 1, then restart at t=20 of frame 3.
        wr_cnt_a = 0;
        adc_a.push_back(12'h0F0); adc_a.push_back(12'h00F); adc_a.push_back(12'hF00);
        exp_a.push_back(12'h00F);
        ifa.fifo_full = 1'b1;
        pulse_a();
        repeat (40) @(negedge clk);
        ifa.fifo_full = 1'b0;
        check_eq("t3_ovf_frame1", ovf_a, 1);
        wait_wr_a("t3_frame2_wr", 1);
        repeat (37) @(negedge clk);
        check_eq("t3_cnt_before_abort", cnt_a, 2);
        check_eq("t3_cs_low_at_t20", ifa.adc_cs_n, 0);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        check_eq("t3_gap_cs_high", ifa.adc_cs_n, 1);
        check_eq("t3_cnt_cleared", cnt_a, 0);
        check_eq("t3_ovf_cleared", ovf_a, 0);
        check_eq("t3_busy", busy_a, 1);
        adc_a.push_back(12'h801); adc_a.push_back(12'h7FE); adc_a.push_back(12'h3C3); adc_a.push_back(12'hC3C);
        exp_a.push_back(12'h801); exp_a.push_back(12'h7FE); exp_a.push_back(12'h3C3); exp_a.push_back(12'hC3C);
        @(negedge clk);
        check_eq("t3_new_frame_cs_low", ifa.adc_cs_n, 0);
        wait_done_a("t3_done_timeout");
        check_eq("t3_cnt", cnt_a, 4);
        check_eq("t3_wr_cnt", wr_cnt_a, 5);
        check_eq("t3_exp_empty", exp_a.size(), 0);

        // Reset at t=25 of frame 1.
        wr_cnt_a = 0;
        pulse_a();
        repeat (25) @(negedge clk);
        check_eq("t4_cs_low_before_rst", ifa.adc_cs_n, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("t4_idle_busy", busy_a, 0);
        check_eq("t4_idle_cs_n", ifa.adc_cs_n, 1);
        check_eq("t4_idle_cnt", cnt_a, 0);
        check_eq("t4_no_wr", wr_cnt_a, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
